// File: rtl/sram_pkg.sv
// Shared definitions for the SPI SRAM access path.
//
// bridge_state_t : state encoding of the 16-bit to 8-bit Wishbone bridge.
package sram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LO   = 3'd1,
    ST_GAP  = 3'd2,
    ST_HI   = 3'd3,
    ST_DONE = 3'd4,
    ST_FAIL = 3'd5
  } bridge_state_t;

endpackage

// File: rtl/wb_word_bridge.sv
// wb_word_bridge
//   Splits a 16-bit Wishbone word access into one or two 8-bit accesses
//   towards the SPI SRAM controller, little-endian (low byte at the even
//   byte address), and returns a single ack or err upstream.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   wbs_*                upstream 16-bit slave port (word address)
//   wbm_*                downstream 8-bit master port (byte address)
//   state_o              debug view of the FSM state
//
// Handshake: upstream request = wbs_cyc_i & wbs_stb_i, sampled only in IDLE
// and only when no completion pulse is on the bus; the request fields are
// latched then and the live inputs are ignored, except wbs_cyc_i which
// aborts the transfer whenever it falls. Downstream, wbm_cyc_o/wbm_stb_o and
// the byte fields stay constant until wbm_ack_i/wbm_err_i/wbm_rty_i; stb is
// dropped for at least one cycle between the two byte accesses.
module wb_word_bridge
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 24
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [ADDR_WIDTH-2:0] wbs_adr_i,
  input  logic [1:0]            wbs_sel_i,
  input  logic [15:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic                  wbs_err_o,
  output logic                  wbs_rty_o,
  output logic [15:0]           wbs_dat_o,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_we_o,
  output logic [ADDR_WIDTH-1:0] wbm_adr_o,
  output logic [7:0]            wbm_dat_o,
  input  logic                  wbm_ack_i,
  input  logic                  wbm_err_i,
  input  logic                  wbm_rty_i,
  input  logic [7:0]            wbm_dat_i,
  output bridge_state_t         state_o
);

  bridge_state_t         state_q;
  logic [ADDR_WIDTH-2:0] adr_q;
  logic                  we_q;
  logic [1:0]            sel_q;
  logic [15:0]           dat_q;
  logic [15:0]           rdata_q;
  logic                  wbs_ack_q;
  logic                  wbs_err_q;
  logic [15:0]           wbs_dat_q;
  logic                  wbm_req_q;
  logic                  wbm_we_q;
  logic [ADDR_WIDTH-1:0] wbm_adr_q;
  logic [7:0]            wbm_dat_q;

  // A retry from the SRAM controller is handled exactly like an error.
  logic                  dn_fail;
  assign dn_fail = wbm_err_i | wbm_rty_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      adr_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= 2'b00;
      dat_q     <= '0;
      rdata_q   <= '0;
      wbs_ack_q <= 1'b0;
      wbs_err_q <= 1'b0;
      wbs_dat_q <= '0;
      wbm_req_q <= 1'b0;
      wbm_we_q  <= 1'b0;
      wbm_adr_q <= '0;
      wbm_dat_q <= '0;
    end else begin
      // Completion outputs are single-cycle pulses.
      wbs_ack_q <= 1'b0;
      wbs_err_q <= 1'b0;
      wbs_dat_q <= '0;

      if ((state_q != ST_IDLE) && !wbs_cyc_i) begin
        // Upstream abandoned the cycle: stop downstream, answer nothing.
        // A downstream ack in this same cycle is deliberately dropped.
        state_q   <= ST_IDLE;
        wbm_req_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            // Blocking on the pulse keeps a master that still holds stb in
            // the ack cycle from starting a second transfer.
            if (wbs_cyc_i && wbs_stb_i && !wbs_ack_q && !wbs_err_q) begin
              adr_q   <= wbs_adr_i;
              we_q    <= wbs_we_i;
              sel_q   <= wbs_sel_i;
              dat_q   <= wbs_dat_i;
              rdata_q <= '0;
              if (wbs_sel_i[0]) begin
                state_q   <= ST_LO;
                wbm_req_q <= 1'b1;
                wbm_we_q  <= wbs_we_i;
                wbm_adr_q <= {wbs_adr_i, 1'b0};
                wbm_dat_q <= wbs_dat_i[7:0];
              end else if (wbs_sel_i[1]) begin
                state_q   <= ST_HI;
                wbm_req_q <= 1'b1;
                wbm_we_q  <= wbs_we_i;
                wbm_adr_q <= {wbs_adr_i, 1'b1};
                wbm_dat_q <= wbs_dat_i[15:8];
              end else begin
                state_q <= ST_DONE;
              end
            end
          end

          ST_LO: begin
            if (dn_fail) begin
              wbm_req_q <= 1'b0;
              state_q   <= ST_FAIL;
            end else if (wbm_ack_i) begin
              rdata_q[7:0] <= wbm_dat_i;
              wbm_req_q    <= 1'b0;
              state_q      <= sel_q[1] ? ST_GAP : ST_DONE;
            end
          end

          // One idle cycle so the controller sees stb low and closes the
          // first SPI frame before the second byte starts.
          ST_GAP: begin
            state_q   <= ST_HI;
            wbm_req_q <= 1'b1;
            wbm_we_q  <= we_q;
            wbm_adr_q <= {adr_q, 1'b1};
            wbm_dat_q <= dat_q[15:8];
          end

          ST_HI: begin
            if (dn_fail) begin
              wbm_req_q <= 1'b0;
              state_q   <= ST_FAIL;
            end else if (wbm_ack_i) begin
              rdata_q[15:8] <= wbm_dat_i;
              wbm_req_q     <= 1'b0;
              state_q       <= ST_DONE;
            end
          end

          ST_DONE: begin
            wbs_ack_q <= 1'b1;
            // Unselected bytes and all write responses read back as zero.
            wbs_dat_q <= we_q ? 16'h0000 :
                         {(sel_q[1] ? rdata_q[15:8] : 8'h00),
                          (sel_q[0] ? rdata_q[7:0]  : 8'h00)};
            state_q   <= ST_IDLE;
          end

          ST_FAIL: begin
            wbs_err_q <= 1'b1;
            state_q   <= ST_IDLE;
          end

          default: begin
            wbm_req_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign wbs_ack_o = wbs_ack_q;
  assign wbs_err_o = wbs_err_q;
  assign wbs_rty_o = 1'b0;
  assign wbs_dat_o = wbs_dat_q;
  assign wbm_cyc_o = wbm_req_q;
  assign wbm_stb_o = wbm_req_q;
  assign wbm_we_o  = wbm_we_q;
  assign wbm_adr_o = wbm_adr_q;
  assign wbm_dat_o = wbm_dat_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_wb_word_bridge.sv
// Testbench for wb_word_bridge: directed corner cases followed by random
// word transfers, with a byte-addressed SRAM responder whose latency and
// error injection are scheduled per byte access by the driver.
module tb_wb_word_bridge;
  import sram_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [22:0]   wbs_adr_i;
  logic [1:0]    wbs_sel_i;
  logic [15:0]   wbs_dat_i;
  logic          wbs_ack_o, wbs_err_o, wbs_rty_o;
  logic [15:0]   wbs_dat_o;
  logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [23:0]   wbm_adr_o;
  logic [7:0]    wbm_dat_o;
  logic          wbm_ack_i, wbm_err_i, wbm_rty_i;
  logic [7:0]    wbm_dat_i;
  bridge_state_t dbg_state;

  wb_word_bridge #(.ADDR_WIDTH(24)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_err_o (wbs_err_o),
    .wbs_rty_o (wbs_rty_o),
    .wbs_dat_o (wbs_dat_o),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_ack_i (wbm_ack_i),
    .wbm_err_i (wbm_err_i),
    .wbm_rty_i (wbm_rty_i),
    .wbm_dat_i (wbm_dat_i),
    .state_o   (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;

  // Byte access record: {we, byte address, write byte (0 for reads)}.
  logic [32:0] exp_q[$];
  logic [32:0] act_q[$];

  // Per-access responder schedule pushed by the driver.
  int plan_lat[$];
  bit plan_err[$];

  // Byte memory behind the responder, also used to predict read data.
  logic [7:0] mem [logic [23:0]];

  int both_cnt  = 0;   // cycles with ack and err high together
  int gap_viol  = 0;   // stb still high the cycle after a byte completed

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- downstream responder + monitor ----------------
  int s_cnt   = 0;
  int cur_lat = 1;
  bit cur_err = 1'b0;
  bit s_prev  = 1'b0;

  initial begin
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    wbm_rty_i = 1'b0;
    wbm_dat_i = 8'h00;
    forever begin
      @(negedge clk);
      if (wbs_ack_o && wbs_err_o) both_cnt++;
      if (s_prev && wbm_stb_o) gap_viol++;
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      wbm_rty_i = 1'b0;
      wbm_dat_i = 8'($urandom);
      s_prev    = 1'b0;
      if (!rst_n || !(wbm_cyc_o && wbm_stb_o)) begin
        s_cnt = 0;
      end else begin
        if (s_cnt == 0) begin
          act_q.push_back({wbm_we_o, wbm_adr_o, (wbm_we_o ? wbm_dat_o : 8'h00)});
          cur_lat = (plan_lat.size() != 0) ? plan_lat.pop_front() : 1;
          cur_err = (plan_err.size() != 0) ? plan_err.pop_front() : 1'b0;
        end
        s_cnt++;
        if (s_cnt >= cur_lat) begin
          if (cur_err) begin
            if ($urandom_range(0, 1) == 1) wbm_err_i = 1'b1;
            else                           wbm_rty_i = 1'b1;
          end else begin
            wbm_ack_i = 1'b1;
            if (wbm_we_o) begin
              mem[wbm_adr_o] = wbm_dat_o;
            end else begin
              if (!mem.exists(wbm_adr_o)) mem[wbm_adr_o] = 8'($urandom);
              wbm_dat_i = mem[wbm_adr_o];
            end
          end
          s_cnt  = 0;
          s_prev = 1'b1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    wbs_adr_i = '0;
    wbs_sel_i = 2'b00;
    wbs_dat_i = '0;
  endtask

  // One upstream word transfer; err_at selects which issued byte access
  // (1 = first, 2 = second, 0 = none) the responder fails.
  task automatic do_txn(input logic we, input logic [22:0] adr, input logic [1:0] sel,
                        input logic [15:0] dat, input int l0, input int l1, input int err_at);
    logic [23:0] ba[$];
    logic [7:0]  bd[$];
    int          lats[2];
    int          nb, n_iss, exp_lat, k, both_base, gap_base;
    logic        exp_err, got;
    logic [15:0] exp_dat;
    logic [23:0] a_lo, a_hi;

    a_lo    = {adr, 1'b0};
    a_hi    = {adr, 1'b1};
    lats[0] = l0;
    lats[1] = l1;
    if (sel[0]) begin ba.push_back(a_lo); bd.push_back(dat[7:0]);  end
    if (sel[1]) begin ba.push_back(a_hi); bd.push_back(dat[15:8]); end
    nb      = ba.size();
    exp_err = (err_at != 0) && (err_at <= nb);
    n_iss   = exp_err ? err_at : nb;

    exp_q.delete();
    act_q.delete();
    plan_lat.delete();
    plan_err.delete();
    for (int i = 0; i < n_iss; i++) begin
      exp_q.push_back({we, ba[i], (we ? bd[i] : 8'h00)});
      plan_lat.push_back(lats[i]);
      plan_err.push_back(err_at == i + 1);
    end

    // Request-to-response cycles: two for an empty select, otherwise each
    // byte costs its downstream latency plus one, plus one for the pulse.
    if (nb == 0) exp_lat = 2;
    else begin
      exp_lat = n_iss + 1;
      for (int i = 0; i < n_iss; i++) exp_lat += lats[i];
    end

    if (!we) begin
      if (sel[0] && !mem.exists(a_lo)) mem[a_lo] = 8'($urandom);
      if (sel[1] && !mem.exists(a_hi)) mem[a_hi] = 8'($urandom);
    end
    exp_dat = 16'h0000;
    if (!we && sel[0]) exp_dat[7:0]  = mem[a_lo];
    if (!we && sel[1]) exp_dat[15:8] = mem[a_hi];

    both_base = both_cnt;
    gap_base  = gap_viol;

    @(negedge clk);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_sel_i = sel;
    wbs_dat_i = dat;
    k   = 0;
    got = 1'b0;
    while (!got && k < 200) begin
      @(negedge clk);
      k++;
      if (wbs_ack_o || wbs_err_o) got = 1'b1;
      else begin
        // Latched request must not follow the live inputs.
        wbs_stb_i = 1'($urandom_range(0, 1));
        wbs_we_i  = 1'($urandom_range(0, 1));
        wbs_adr_i = 23'($urandom);
        wbs_sel_i = 2'($urandom);
        wbs_dat_i = 16'($urandom);
      end
    end
    check("resp_seen", got, 1'b1);
    check("latency", k, exp_lat);
    check("ack", wbs_ack_o, !exp_err);
    check("err", wbs_err_o, exp_err);
    if (!exp_err) check("rdata", wbs_dat_o, exp_dat);
    idle_inputs();

    @(negedge clk);
    check("pulse_width", {wbs_ack_o, wbs_err_o}, 2'b00);
    check("n_access", act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      check("access", act_q[i], exp_q[i]);
    check("ack_err_excl", both_cnt - both_base, 0);
    check("stb_gap", gap_viol - gap_base, 0);
  endtask

  // Wait (bounded) until the responder has logged n byte accesses.
  task automatic wait_accesses(input int n, output logic ok);
    int k;
    k  = 0;
    ok = 1'b0;
    while (!ok && k < 50) begin
      @(negedge clk);
      #1;
      k++;
      if (act_q.size() >= n) ok = 1'b1;
    end
    check("access_started", ok, 1'b1);
  endtask

  task automatic watch_no_resp(input string tag, input int cycles);
    int cnt;
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (wbs_ack_o || wbs_err_o) cnt++;
    end
    check(tag, cnt, 0);
  endtask

  // Upstream drops cyc while the high byte is outstanding.
  task automatic abort_cyc_hi();
    logic ok;
    exp_q.delete();
    act_q.delete();
    plan_lat.delete();
    plan_err.delete();
    plan_lat.push_back(1);  plan_err.push_back(1'b0);
    plan_lat.push_back(30); plan_err.push_back(1'b0);
    @(negedge clk);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = 1'b0;
    wbs_adr_i = 23'h012345;
    wbs_sel_i = 2'b11;
    wbs_dat_i = 16'h0000;
    wait_accesses(2, ok);
    check("hi_active", {wbm_cyc_o, wbm_stb_o, wbm_adr_o}, {2'b11, 24'h02468B});
    idle_inputs();
    @(posedge clk);
    #1;
    check("cycdrop_cyc", wbm_cyc_o, 1'b0);
    check("cycdrop_stb", wbm_stb_o, 1'b0);
    check("cycdrop_state", dbg_state, ST_IDLE);
    watch_no_resp("cycdrop_no_resp", 8);
    check("cycdrop_accesses", act_q.size(), 2);
    plan_lat.delete();
    plan_err.delete();
  endtask

  // Reset pulsed while the low byte is outstanding.
  task automatic abort_reset_lo();
    logic ok;
    exp_q.delete();
    act_q.delete();
    plan_lat.delete();
    plan_err.delete();
    plan_lat.push_back(30); plan_err.push_back(1'b0);
    plan_lat.push_back(1);  plan_err.push_back(1'b0);
    @(negedge clk);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = 1'b1;
    wbs_adr_i = 23'h000777;
    wbs_sel_i = 2'b11;
    wbs_dat_i = 16'hC3A5;
    wait_accesses(1, ok);
    check("lo_active", dbg_state, ST_LO);
    rst_n = 1'b0;
    #1;
    check("rst_cyc", wbm_cyc_o, 1'b0);
    check("rst_stb", wbm_stb_o, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_outs", {wbm_we_o, wbm_adr_o, wbm_dat_o, wbs_ack_o, wbs_err_o, wbs_dat_o}, '0);
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    watch_no_resp("rst_no_resp", 8);
    check("rst_accesses", act_q.size(), 1);
    plan_lat.delete();
    plan_err.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", dbg_state, ST_IDLE);
    check("reset_wbm", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o}, '0);
    check("reset_wbs", {wbs_ack_o, wbs_err_o, wbs_rty_o, wbs_dat_o}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Word write, both bytes, then read it back.
    do_txn(1'b1, 23'h000010, 2'b11, 16'hBEEF, 2, 3, 0);
    check("mem_lo", mem[24'h000020], 8'hEF);
    check("mem_hi", mem[24'h000021], 8'hBE);
    do_txn(1'b0, 23'h000010, 2'b11, 16'h0000, 1, 1, 0);
    // Known pattern in memory, word read.
    mem[24'h000020] = 8'hAA;
    mem[24'h000021] = 8'h55;
    do_txn(1'b0, 23'h000010, 2'b11, 16'h0000, 3, 2, 0);
    // High byte only at the top of the address space.
    do_txn(1'b0, 23'h7FFFFF, 2'b10, 16'h0000, 2, 1, 0);
    // Low byte only.
    do_txn(1'b0, 23'h000123, 2'b01, 16'h0000, 1, 1, 0);
    // Empty select, read and write.
    do_txn(1'b0, 23'h000055, 2'b00, 16'h1234, 1, 1, 0);
    do_txn(1'b1, 23'h000056, 2'b00, 16'h1234, 1, 1, 0);
    // Error on the low byte of a word write: high byte never issued.
    do_txn(1'b1, 23'h000200, 2'b11, 16'hCAFE, 2, 1, 1);
    // Error on the high byte of a word read.
    do_txn(1'b0, 23'h000201, 2'b11, 16'h0000, 1, 2, 2);

    abort_cyc_hi();
    abort_reset_lo();

    for (int n = 0; n < 40; n++) begin
      do_txn(1'($urandom_range(0, 1)), 23'($urandom), 2'($urandom_range(0, 3)),
             16'($urandom), $urandom_range(1, 4), $urandom_range(1, 4),
             ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
